// File: rtl/frontend_redirect_ctrl.sv
// rtl/frontend_redirect_ctrl.sv - frontend flush/restart sequencer (optional perf counters: REDIRECT_PERF_EN)
module frontend_redirect_ctrl #(
    parameter int FSQ_WIDTH   = 4,
    parameter int VADDR_SIZE  = 39,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  be_valid,
    input  logic [FSQ_WIDTH:0]    be_fsq,
    input  logic [VADDR_SIZE-1:0] be_target,
    input  logic                  pd_valid,
    input  logic [FSQ_WIDTH:0]    pd_fsq,
    input  logic [VADDR_SIZE-1:0] pd_target,
    output logic                  pd_ready,
    input  logic                  ibuf_full,
    output logic                  flush,
    output logic [VADDR_SIZE-1:0] redirect_pc,
    output logic [FSQ_WIDTH:0]    redirect_fsq,
    output logic                  redirect_src,
    output logic                  fetch_stall,
    output logic [31:0]           perf_be_cnt,
    output logic [31:0]           perf_pd_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES);

    state_t                  r_state;
    state_t                  w_state_next;
    logic [3:0]              r_hold_cnt;
    logic [3:0]              w_hold_cnt_next;
    logic [VADDR_SIZE-1:0]   r_redirect_pc;
    logic [FSQ_WIDTH:0]      r_redirect_fsq;
    logic                    r_redirect_src;

    logic                    w_pd_accept;
    logic                    w_accept;
    logic [VADDR_SIZE-1:0]   w_sel_target;
    logic [FSQ_WIDTH:0]      w_sel_fsq;
    logic [FSQ_WIDTH:0]      w_fsq_inc;

    // Restart one entry past the redirecting stream; wrapping the index flips the direction bit.
    function automatic logic [FSQ_WIDTH:0] fsq_next(input logic [FSQ_WIDTH:0] f);
        logic [FSQ_WIDTH:0] r;
        if (f[FSQ_WIDTH-1:0] == {FSQ_WIDTH{1'b1}}) begin
            r = {~f[FSQ_WIDTH], {FSQ_WIDTH{1'b0}}};
        end else begin
            r = {f[FSQ_WIDTH], f[FSQ_WIDTH-1:0] + 1'b1};
        end
        return r;
    endfunction

    assign w_pd_accept  = pd_valid && (r_state == IDLE) && !ibuf_full && !be_valid;
    assign w_accept     = be_valid || w_pd_accept;
    assign w_sel_target = be_valid ? be_target : pd_target;
    assign w_sel_fsq    = be_valid ? be_fsq : pd_fsq;
    assign w_fsq_inc    = fsq_next(w_sel_fsq);

    always_comb begin
        w_state_next    = r_state;
        w_hold_cnt_next = r_hold_cnt;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = FLUSH;
                end
            end
            FLUSH: begin
                w_hold_cnt_next = HOLD_LOAD;
                w_state_next    = be_valid ? FLUSH : HOLD;
            end
            HOLD: begin
                w_hold_cnt_next = r_hold_cnt - 4'd1;
                if (be_valid) begin
                    w_state_next = FLUSH;
                end else if (r_hold_cnt == 4'd1) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_hold_cnt <= 4'd0;
        end else begin
            r_state    <= w_state_next;
            r_hold_cnt <= w_hold_cnt_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_redirect_pc  <= '0;
            r_redirect_fsq <= '0;
            r_redirect_src <= 1'b0;
        end else if (w_accept) begin
            r_redirect_pc  <= w_sel_target;
            r_redirect_fsq <= w_fsq_inc;
            r_redirect_src <= be_valid;
        end
    end

`ifdef REDIRECT_PERF_EN
    logic [31:0] r_perf_be_cnt;
    logic [31:0] r_perf_pd_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_be_cnt <= '0;
            r_perf_pd_cnt <= '0;
        end else begin
            if (be_valid) begin
                r_perf_be_cnt <= r_perf_be_cnt + 32'd1;
            end
            if (w_pd_accept) begin
                r_perf_pd_cnt <= r_perf_pd_cnt + 32'd1;
            end
        end
    end

    assign perf_be_cnt = r_perf_be_cnt;
    assign perf_pd_cnt = r_perf_pd_cnt;
`else
    assign perf_be_cnt = '0;
    assign perf_pd_cnt = '0;
`endif

    assign pd_ready     = w_pd_accept;
    assign flush        = (r_state == FLUSH);
    assign fetch_stall  = (r_state != IDLE);
    assign redirect_pc  = r_redirect_pc;
    assign redirect_fsq = r_redirect_fsq;
    assign redirect_src = r_redirect_src;

endmodule

// File: tb/tb_frontend_redirect_ctrl.sv
// tb/tb_frontend_redirect_ctrl.sv - scoreboard bench for frontend_redirect_ctrl
module tb_frontend_redirect_ctrl;

    localparam int FW   = 4;
    localparam int VA   = 39;
    localparam int HOLD = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          be_valid;
    logic [FW:0]   be_fsq;
    logic [VA-1:0] be_target;
    logic          pd_valid;
    logic [FW:0]   pd_fsq;
    logic [VA-1:0] pd_target;
    logic          pd_ready;
    logic          ibuf_full;
    logic          flush;
    logic [VA-1:0] redirect_pc;
    logic [FW:0]   redirect_fsq;
    logic          redirect_src;
    logic          fetch_stall;
    logic [31:0]   perf_be_cnt;
    logic [31:0]   perf_pd_cnt;

    typedef struct packed {
        logic [VA-1:0] pc;
        logic [FW:0]   fsq;
        logic          src;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    frontend_redirect_ctrl #(
        .FSQ_WIDTH(FW), .VADDR_SIZE(VA), .HOLD_CYCLES(HOLD)
    ) dut (
        .clk(clk), .rst(rst),
        .be_valid(be_valid), .be_fsq(be_fsq), .be_target(be_target),
        .pd_valid(pd_valid), .pd_fsq(pd_fsq), .pd_target(pd_target),
        .pd_ready(pd_ready), .ibuf_full(ibuf_full),
        .flush(flush), .redirect_pc(redirect_pc), .redirect_fsq(redirect_fsq),
        .redirect_src(redirect_src), .fetch_stall(fetch_stall),
        .perf_be_cnt(perf_be_cnt), .perf_pd_cnt(perf_pd_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic count_stall(input string name);
        int  n;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (fetch_stall) n++;
            else break;
        end
        chk(name, 64'(n), 64'(HOLD + 1));
    endtask

    task automatic issue_be(input logic [FW:0] f, input logic [VA-1:0] t, input logic [FW:0] f_exp);
        be_valid  = 1'b1;
        be_fsq    = f;
        be_target = t;
        exp_q.push_back('{pc: t, fsq: f_exp, src: 1'b1});
    endtask

    // Monitor: every flush pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (flush === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_flush", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("redirect_pc",  64'(redirect_pc),  64'(e.pc));
                chk("redirect_fsq", 64'(redirect_fsq), 64'(e.fsq));
                chk("redirect_src", 64'(redirect_src), 64'(e.src));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_be;
        logic [31:0] exp_pd;
        rst = 1'b1; be_valid = 1'b0; be_fsq = '0; be_target = '0;
        pd_valid = 1'b1; pd_fsq = '0; pd_target = '0; ibuf_full = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_pd_ready", 64'(pd_ready), 64'd1);
        chk("rst_flush", 64'(flush), 64'd0);
        cyc();
        rst = 1'b0; pd_valid = 1'b0;

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_flush", 64'(flush), 64'd0);
            chk("idle_stall", 64'(fetch_stall), 64'd0);
        end
        chk("idle_pc",  64'(redirect_pc),  64'd0);
        chk("idle_fsq", 64'(redirect_fsq), 64'd0);
        chk("idle_src", 64'(redirect_src), 64'd0);
        chk("idle_perf_be", 64'(perf_be_cnt), 64'd0);
        chk("idle_perf_pd", 64'(perf_pd_cnt), 64'd0);
        chk("idle_pd_ready", 64'(pd_ready), 64'd0);

        // Predecode redirect
        cyc();
        pd_valid = 1'b1; pd_fsq = 5'b0_0011; pd_target = 39'h1000;
        exp_q.push_back('{pc: 39'h1000, fsq: 5'b0_0100, src: 1'b0});
        @(negedge clk);
        chk("pd_ready_idle", 64'(pd_ready), 64'd1);
        cyc();
        pd_valid = 1'b0;
        count_stall("pd_stall_len");
        chk("pc_holds", 64'(redirect_pc), 64'h1000);

        // Backend wrap in both directions
        cyc();
        issue_be(5'b0_1111, 39'h2000, 5'b1_0000);
        cyc();
        be_valid = 1'b0;
        count_stall("wrap0_stall_len");
        cyc();
        issue_be(5'b1_1111, 39'h2100, 5'b0_0000);
        cyc();
        be_valid = 1'b0;
        count_stall("wrap1_stall_len");

        // Collision: backend wins, predecode not accepted
        cyc();
        issue_be(5'b1_0010, 39'h3000, 5'b1_0011);
        pd_valid = 1'b1; pd_fsq = 5'b0_0101; pd_target = 39'h3333;
        @(negedge clk);
        chk("collide_pd_ready", 64'(pd_ready), 64'd0);
        cyc();
        be_valid = 1'b0; pd_valid = 1'b0;
        count_stall("collide_stall_len");

        // Backend during HOLD with counter at 1
        cyc();
        issue_be(5'b0_0111, 39'h4000, 5'b0_1000);
        cyc();
        be_valid = 1'b0;
        @(negedge clk);
        chk("hold_stall_a", 64'(fetch_stall), 64'd1);
        cyc();
        pd_valid = 1'b1; pd_fsq = 5'b0_0001; pd_target = 39'h4444;
        @(negedge clk);
        chk("hold_pd_ready", 64'(pd_ready), 64'd0);
        chk("hold_stall_b", 64'(fetch_stall), 64'd1);
        cyc();
        pd_valid = 1'b0;
        issue_be(5'b0_1001, 39'h5000, 5'b0_1010);
        @(negedge clk);
        chk("hold_stall_c", 64'(fetch_stall), 64'd1);
        chk("hold_no_flush", 64'(flush), 64'd0);
        cyc();
        be_valid = 1'b0;
        count_stall("rehold_stall_len");

        // Predecode blocked by full IBuffer, then released
        cyc();
        pd_valid = 1'b1; pd_fsq = 5'b1_1111; pd_target = 39'h6000; ibuf_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("full_pd_ready", 64'(pd_ready), 64'd0);
            cyc();
        end
        ibuf_full = 1'b0;
        exp_q.push_back('{pc: 39'h6000, fsq: 5'b0_0000, src: 1'b0});
        @(negedge clk);
        chk("release_pd_ready", 64'(pd_ready), 64'd1);
        cyc();
        pd_valid = 1'b0;
        count_stall("release_stall_len");

        // Back-to-back backend pulses
        cyc();
        issue_be(5'b0_0001, 39'h7100, 5'b0_0010);
        cyc();
        issue_be(5'b0_0010, 39'h7200, 5'b0_0011);
        @(negedge clk);
        chk("b2b_flush1", 64'(flush), 64'd1);
        cyc();
        be_valid = 1'b0;
        count_stall("b2b_stall_len");

`ifdef REDIRECT_PERF_EN
        exp_be = 32'd7;
        exp_pd = 32'd2;
`else
        exp_be = 32'd0;
        exp_pd = 32'd0;
`endif
        chk("perf_be", 64'(perf_be_cnt), 64'(exp_be));
        chk("perf_pd", 64'(perf_pd_cnt), 64'(exp_pd));

        // Asynchronous reset in HOLD
        cyc();
        issue_be(5'b0_0000, 39'h7000, 5'b0_0001);
        cyc();
        be_valid = 1'b0;
        cyc();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_stall", 64'(fetch_stall), 64'd0);
        chk("arst_flush", 64'(flush), 64'd0);
        chk("arst_pc", 64'(redirect_pc), 64'd0);
        chk("arst_fsq", 64'(redirect_fsq), 64'd0);
        chk("arst_src", 64'(redirect_src), 64'd0);
        chk("arst_perf_be", 64'(perf_be_cnt), 64'd0);
        cyc();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("arst_idle", 64'(fetch_stall), 64'd0);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/frontend_redirect_ctrl.md
# frontend_redirect_ctrl

Sequences frontend flushes and restarts for the fetch pipeline (BPU → FSQ → ICache → predecode → IBuffer). It arbitrates between backend redirects and predecode redirects, and broadcasts a one-cycle flush with a registered target PC and the restart FSQ index. It then holds fetch stalled for a programmable number of cycles so every stage drains before the BPU restarts.

## Interface
Parameters:
- FSQ_WIDTH, 4, FSQ entry index width; the full index adds one wrap (direction) bit on top.
- VADDR_SIZE, 39, virtual address width.
- HOLD_CYCLES, 2, stall cycles after the flush pulse; legal range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- be_valid  in  1  backend redirect request, single-cycle pulse, always accepted
- be_fsq  in  FSQ_WIDTH+1  {dir, idx} of the redirecting stream
- be_target  in  VADDR_SIZE  backend restart PC
- pd_valid  in  1  predecode redirect request, held until accepted
- pd_fsq  in  FSQ_WIDTH+1  {dir, idx} of the redirecting stream
- pd_target  in  VADDR_SIZE  predecode restart PC
- pd_ready  out  1  predecode request accepted this cycle
- ibuf_full  in  1  instruction buffer full
- flush  out  1  one-cycle flush to BPU, ICache, predecode and IBuffer
- redirect_pc  out  VADDR_SIZE  restart PC, valid while flush=1
- redirect_fsq  out  FSQ_WIDTH+1  FSQ write index to restart at, valid while flush=1
- redirect_src  out  1  source of the flush: 1 = backend, 0 = predecode
- fetch_stall  out  1  BPU must not issue
- perf_be_cnt  out  32  backend redirects accepted
- perf_pd_cnt  out  32  predecode redirects accepted

## Operation
- FSM states: IDLE, FLUSH, HOLD.
- Acceptance conditions:
  - A backend request is accepted in any state when be_valid=1.
  - A predecode request is accepted when pd_valid=1, state=IDLE, ibuf_full=0 and be_valid=0.
  - pd_ready is combinational from these terms.
- Arbitration:
  - Backend strictly beats predecode.
  - When both arrive in the same cycle, pd_ready=0. The predecode source is flushed by the resulting pulse and must drop its request.
- On acceptance:
  - Register the target into redirect_pc and set redirect_src.
  - Compute redirect_fsq = fsq + 1 with wrap: if idx equals 2^FSQ_WIDTH-1, idx becomes 0 and dir toggles; otherwise dir is unchanged.
  - Next state is FLUSH.
- FLUSH:
  - flush=1 and fetch_stall=1 for exactly one cycle.
  - Load hold counter with HOLD_CYCLES; next state HOLD.
- HOLD:
  - fetch_stall=1; the counter decrements each cycle.
  - Return to IDLE in the cycle after the counter reads 1.
  - pd_ready=0 throughout; predecode requests from flushed streams are never accepted.
- A backend request during FLUSH or HOLD re-enters FLUSH the next cycle. The new target, index and source overwrite the old ones and the hold counter reloads. Back-to-back backend pulses therefore give back-to-back flush pulses.
- In IDLE, fetch_stall=0 and flush=0.
- ibuf_full does not affect backend acceptance or the FLUSH/HOLD sequencing.

## Timing
- Acceptance in cycle N → flush=1 with redirect_pc, redirect_fsq and redirect_src valid in N+1.
- fetch_stall=1 from N+1 through N+1+HOLD_CYCLES; IDLE from N+2+HOLD_CYCLES.
- Minimum spacing between two predecode flushes is HOLD_CYCLES+2 cycles.
- Reset values: state IDLE, flush 0, fetch_stall 0, redirect_pc 0, redirect_fsq 0, redirect_src 0, perf counters 0, pd_ready follows its combinational terms (1 if pd_valid and not full).
- Reset mid-FLUSH or mid-HOLD forces IDLE immediately (asynchronous), and the outputs take their reset values.
- redirect_pc, redirect_fsq and redirect_src hold their last values outside FLUSH.

## Configuration
- REDIRECT_PERF_EN defined:
  - perf_be_cnt increments on each accepted backend request and perf_pd_cnt on each accepted predecode request.
  - Both counters are 32 bits, wrap at 2^32, and reset to 0.
- REDIRECT_PERF_EN undefined: no counter flops are instantiated and both perf outputs are tied to 0.

## Test plan
- Reset then idle: pd_valid=0, be_valid=0 for 10 cycles → flush=0, fetch_stall=0, all outputs 0.
- Predecode redirect, pd_fsq={0,3}, pd_target=0x1000, IDLE, ibuf_full=0:
  - same cycle: pd_ready=1
  - next cycle: flush=1, redirect_pc=0x1000, redirect_fsq={0,4}, redirect_src=0
  - with HOLD_CYCLES=2: fetch_stall high 3 cycles, then IDLE.
- Wrap: be_fsq={0,15}, FSQ_WIDTH=4 → redirect_fsq={1,0}, redirect_src=1.
- Collision: be_valid and pd_valid in the same IDLE cycle → pd_ready=0; the single flush carries be_target; perf_pd_cnt unchanged.
- Backend redirect during HOLD, counter=1 → flush again next cycle with the new PC; fetch_stall continuous for HOLD_CYCLES+1 further cycles.
- pd_valid held with ibuf_full=1 for 5 cycles → pd_ready=0 throughout; release ibuf_full → pd_ready=1 the same cycle, flush the next.
